trng_health: RTL and testbench
==============================

// Module: trng_health
// PURPOSE
//  Online health-test and buffering stage downstream of the ring-oscillator entropy source.
//  - Accepts 32-bit raw entropy words over a valid/ack handshake.
//  - Serially runs a Repetition Count Test (RCT) and an Adaptive Proportion Test (APT) on every bit.
//  - Presents passing words to firmware through the standard cs/we/address register API.
//  - Withholds all words while any test failure is latched.
// PARAMETERS
//  RCT_CUTOFF  8'd32    run of identical bits that flags an RCT failure (valid 2..255)
//  APT_WINDOW  16'd1024 APT window length in bits (power of two, >= 64)
//  APT_CUTOFF  16'd589  matches of the window's first bit (first bit included) that flag an APT failure
// PORTS
//  clk         in   1   system clock
//  reset_n     in   1   synchronous reset, active low
//  raw_data    in   32  raw entropy word from source
//  raw_valid   in   1   raw_data valid
//  raw_ack     out  1   word consumed this cycle
//  cs          in   1   register access select
//  we          in   1   1 = write, 0 = read
//  address     in   8   register address
//  write_data  in   32  write data
//  read_data   out  32  read data, combinational, 0 when not reading a defined address
//  ready       out  1   equals cs, same cycle
// BEHAVIOUR
//  Clock and reset:
//  - One clock; reset is synchronous and active-low.
//  - Reset values:
//    - state = IDLE, raw_ack = 0.
//    - data_valid = 0, rct_fail = 0, apt_fail = 0.
//    - data_reg = 0, word_ctr = 0, all test counters = 0.
//  Registers:
//  - 0x08 CTRL, write-only: bit0 = 1 clears rct_fail/apt_fail, resets RCT/APT state, aborts any word in test.
//  - 0x09 STATUS, read: {29'h0, apt_fail, rct_fail, data_valid}.
//  - 0x0a WORDS, read: count of words committed, 32-bit, wraps 0xffffffff -> 0.
//  - 0x20 DATA, read: returns data_reg; the read clears data_valid at that clock edge.
//  - Reads of undefined addresses return 0. Writes to any address other than CTRL are ignored.
//  FSM: IDLE -> TEST -> COMMIT -> IDLE
//  - IDLE:
//    - raw_ack = raw_valid & ~fail, combinational.
//    - On the ack edge (E0): capture raw_data into shift_reg, bit_idx = 0, go to TEST.
//  - TEST:
//    - Edges E1..E32 each test one bit, MSB first (bit 31 on E1).
//    - After the bit on E32, go to COMMIT.
//  - COMMIT:
//    - If fail is set: discard the word, go to IDLE.
//    - Else if data_valid = 0: load data_reg, set data_valid, word_ctr += 1, go to IDLE.
//    - Else: hold in COMMIT (backpressure; raw_ack stays low).
//  - Latency: with the output empty, data_valid rises after edge E33.
//  RCT, per tested bit b:
//  - If rct_cnt != 0 and b == rct_last: rct_cnt = min(rct_cnt + 1, 255). Otherwise rct_cnt = 1.
//  - rct_last = b.
//  - New rct_cnt >= RCT_CUTOFF sets rct_fail (sticky).
//  - First bit after reset or clear starts a run of 1.
//  APT, per tested bit:
//  - apt_pos == 0: apt_ref = b, apt_cnt = 1.
//  - Otherwise: apt_cnt += (b == apt_ref).
//  - apt_pos increments and wraps at APT_WINDOW - 1.
//  - When the bit at apt_pos = APT_WINDOW - 1 is tested: if the final apt_cnt >= APT_CUTOFF, set apt_fail.
//  - Windows span word boundaries; state persists across words.
//  Failure and clear:
//  - fail = rct_fail | apt_fail.
//  - A failure detected mid-word taints that word: it is discarded in COMMIT.
//  - A word already in data_reg is kept and remains readable.
//  - CTRL clear has priority over a failure detected in the same cycle; the failure is not latched.
//  - CTRL clear in TEST or COMMIT: discard the word, go to IDLE next edge, raw_ack = 0 that cycle.
//  - CTRL clear in IDLE also forces raw_ack = 0 that cycle (no word is accepted on the clear edge).
//  Other rules:
//  - A DATA read and a COMMIT in the same cycle cannot collide: COMMIT requires data_valid = 0.
//  - reset_n low mid-word aborts the word and drops it; there is no partial commit.
// TESTING
//  - Alternating input 0xAAAAAAAA on raw_valid:
//    -> raw_ack 1 cycle; data_valid after E33; DATA read = 0xAAAAAAAA; WORDS = 1; STATUS = 0x1 before read, 0x0 after.
//  - Words 0x00000000 then 0x0000FFFF, RCT_CUTOFF = 32:
//    -> rct_fail on the 32nd zero (last bit of word 1); word 1 discarded; STATUS = 0x2; no raw_ack while failed.
//    -> CTRL write 0x1 -> STATUS = 0x0; next word accepted.
//  - 32 copies of 0x0F0F0F0F (1024 bits, 512 matches):
//    -> no apt_fail.
//    -> with 0xFFFEFFFF-patterned windows (matches >= 589): apt_fail at the window end; STATUS bit2 = 1.
//  - Two words presented, DATA not read:
//    -> 2nd word holds in COMMIT; raw_ack low for the 3rd word.
//    -> DATA read -> 2nd word commits the next edge; WORDS = 2.
//  - CTRL clear at E10 of a word, then reset_n pulse at E5 of the next word:
//    -> both words dropped; no data_valid; WORDS unchanged (0 after reset).
//  - Register API: read 0x33 -> 0; write to 0x20 ignored; ready = cs in the same cycle.

Source files
------------

// File: rtl/trng_health.sv
// Online RCT/APT health tests on raw ring-oscillator entropy words, with a
// single-word output buffer exposed over the cs/we/address register API.
module trng_health #(
  parameter logic [7:0]  RCT_CUTOFF = 8'd32,
  parameter logic [15:0] APT_WINDOW = 16'd1024,
  parameter logic [15:0] APT_CUTOFF = 16'd589
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] raw_data,
  input  logic        raw_valid,
  output logic        raw_ack,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_TEST   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam int PW = $clog2(APT_WINDOW);
  localparam logic [PW-1:0] APT_LAST = PW'(APT_WINDOW - 16'd1);

  localparam logic [7:0] A_CTRL   = 8'h08;
  localparam logic [7:0] A_STATUS = 8'h09;
  localparam logic [7:0] A_WORDS  = 8'h0a;
  localparam logic [7:0] A_DATA   = 8'h20;

  logic [1:0]    state_q, state_d;
  logic [31:0]   shift_q, shift_d;
  logic [4:0]    bit_idx_q, bit_idx_d;
  logic [31:0]   data_q, data_d;
  logic          data_valid_q, data_valid_d;
  logic [31:0]   word_ctr_q, word_ctr_d;
  logic          rct_last_q, rct_last_d;
  logic [7:0]    rct_cnt_q, rct_cnt_d;
  logic          rct_fail_q, rct_fail_d;
  logic          apt_ref_q, apt_ref_d;
  logic [15:0]   apt_cnt_q, apt_cnt_d;
  logic [PW-1:0] apt_pos_q, apt_pos_d;
  logic          apt_fail_q, apt_fail_d;

  logic        rd_en, clr, data_rd, fail, test_bit;
  logic [7:0]  rct_cnt_nx;
  logic [15:0] apt_cnt_nx;
  logic        rct_hit, apt_hit;
  logic        unused_wd;

  assign unused_wd = ^write_data[31:1];

  assign ready    = cs;
  assign rd_en    = cs & ~we;
  assign clr      = cs & we & (address == A_CTRL) & write_data[0];
  assign data_rd  = rd_en & (address == A_DATA);
  assign fail     = rct_fail_q | apt_fail_q;
  // A clear edge never accepts a word, so the new test state starts clean.
  assign raw_ack  = reset_n & (state_q == S_IDLE) & raw_valid & ~fail & ~clr;
  assign test_bit = shift_q[31];

  assign rct_cnt_nx = (rct_cnt_q != 8'd0 && test_bit == rct_last_q)
                      ? ((rct_cnt_q == 8'hff) ? 8'hff : rct_cnt_q + 8'd1)
                      : 8'd1;
  assign apt_cnt_nx = (apt_pos_q == '0) ? 16'd1
                      : apt_cnt_q + {15'd0, test_bit == apt_ref_q};
  assign rct_hit    = rct_cnt_nx >= RCT_CUTOFF;
  assign apt_hit    = (apt_pos_q == APT_LAST) && (apt_cnt_nx >= APT_CUTOFF);

  always_comb begin
    read_data = 32'd0;
    if (rd_en) begin
      case (address)
        A_STATUS: read_data = {29'd0, apt_fail_q, rct_fail_q, data_valid_q};
        A_WORDS:  read_data = word_ctr_q;
        A_DATA:   read_data = data_q;
        default:  read_data = 32'd0;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    data_d       = data_q;
    data_valid_d = data_valid_q & ~data_rd;
    word_ctr_d   = word_ctr_q;
    rct_last_d   = rct_last_q;
    rct_cnt_d    = rct_cnt_q;
    rct_fail_d   = rct_fail_q;
    apt_ref_d    = apt_ref_q;
    apt_cnt_d    = apt_cnt_q;
    apt_pos_d    = apt_pos_q;
    apt_fail_d   = apt_fail_q;
    if (clr) begin
      rct_cnt_d  = 8'd0;
      rct_fail_d = 1'b0;
      apt_cnt_d  = 16'd0;
      apt_pos_d  = '0;
      apt_fail_d = 1'b0;
      state_d    = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (raw_ack) begin
            shift_d   = raw_data;
            bit_idx_d = 5'd0;
            state_d   = S_TEST;
          end
        end
        S_TEST: begin
          // Rotate so the captured word is intact again after 32 bits.
          shift_d    = {shift_q[30:0], shift_q[31]};
          bit_idx_d  = bit_idx_q + 5'd1;
          rct_last_d = test_bit;
          rct_cnt_d  = rct_cnt_nx;
          apt_cnt_d  = apt_cnt_nx;
          apt_pos_d  = apt_pos_q + 1'b1;
          if (apt_pos_q == '0) apt_ref_d = test_bit;
          if (rct_hit) rct_fail_d = 1'b1;
          if (apt_hit) apt_fail_d = 1'b1;
          if (bit_idx_q == 5'd31) state_d = S_COMMIT;
        end
        S_COMMIT: begin
          if (fail) begin
            state_d = S_IDLE;
          end else if (!data_valid_q) begin
            data_d       = shift_q;
            data_valid_d = 1'b1;
            word_ctr_d   = word_ctr_q + 32'd1;
            state_d      = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      shift_q      <= 32'd0;
      bit_idx_q    <= 5'd0;
      data_q       <= 32'd0;
      data_valid_q <= 1'b0;
      word_ctr_q   <= 32'd0;
      rct_last_q   <= 1'b0;
      rct_cnt_q    <= 8'd0;
      rct_fail_q   <= 1'b0;
      apt_ref_q    <= 1'b0;
      apt_cnt_q    <= 16'd0;
      apt_pos_q    <= '0;
      apt_fail_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      word_ctr_q   <= word_ctr_d;
      rct_last_q   <= rct_last_d;
      rct_cnt_q    <= rct_cnt_d;
      rct_fail_q   <= rct_fail_d;
      apt_ref_q    <= apt_ref_d;
      apt_cnt_q    <= apt_cnt_d;
      apt_pos_q    <= apt_pos_d;
      apt_fail_q   <= apt_fail_d;
    end
  end

endmodule

// File: tb/tb_trng_health.sv
// Bench for trng_health: directed scenarios, then randomized words checked
// through a scoreboard fed by a bit-stream reference model.
module tb_trng_health;

  localparam logic [7:0] A_CTRL   = 8'h08;
  localparam logic [7:0] A_STATUS = 8'h09;
  localparam logic [7:0] A_WORDS  = 8'h0a;
  localparam logic [7:0] A_DATA   = 8'h20;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] raw_data;
  logic        raw_valid;
  logic        raw_ack;
  logic        cs, we;
  logic [7:0]  address;
  logic [31:0] write_data, read_data;
  logic        ready;

  trng_health dut (
    .clk(clk), .reset_n(reset_n), .raw_data(raw_data), .raw_valid(raw_valid),
    .raw_ack(raw_ack), .cs(cs), .we(we), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int words_exp = 0;
  logic [31:0] exp_q[$];
  bit prod_done = 0;

  // Reference model: run length, window position/reference/match count.
  int m_run = 0;
  bit m_run_bit = 0;
  int m_pos = 0;
  bit m_ref = 0;
  int m_match = 0;

  function automatic bit model_word(input logic [31:0] w);
    bit bad = 0;
    for (int i = 31; i >= 0; i--) begin
      bit b = w[i];
      m_run = (m_run > 0 && b == m_run_bit) ? m_run + 1 : 1;
      m_run_bit = b;
      if (m_run >= 32) bad = 1;
      if (m_pos == 0) begin m_ref = b; m_match = 1; end
      else if (b == m_ref) m_match++;
      if (m_pos == 1023 && m_match >= 589) bad = 1;
      m_pos = (m_pos + 1) % 1024;
    end
    if (bad) begin m_run = 0; m_pos = 0; end  // monitor clears on any failure
    return !bad;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [7:0] a, output logic [31:0] d);
    cs = 1; we = 0; address = a;
    #1 d = read_data;
    chk("ready_eq_cs", {31'd0, ready}, 32'd1);
    cs = 0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    cs = 1; we = 1; address = a; write_data = d;
    wait_edges(1);
    cs = 0; we = 0;
  endtask

  task automatic rd_data_edge();
    cs = 1; we = 0; address = A_DATA;
    wait_edges(1);
    cs = 0;
  endtask

  task automatic send_word(input logic [31:0] w);
    int k = 0;
    raw_data = w; raw_valid = 1;
    #1;
    while (!raw_ack && k < 300) begin
      @(posedge clk); #2; k++;
    end
    chk("raw_ack_handshake", {31'd0, raw_ack}, 32'd1);
    @(posedge clk); #1;
    raw_valid = 0;
  endtask

  task automatic run_word(input logic [31:0] w, input logic [31:0] exp_st, input string tag);
    logic [31:0] d;
    send_word(w);
    wait_edges(33);
    peek(A_STATUS, d);
    chk(tag, d, exp_st);
    if (exp_st[0]) begin
      peek(A_DATA, d);
      chk({tag, "_data"}, d, w);
      words_exp++;
      rd_data_edge();
    end
  endtask

  task automatic producer();
    logic [31:0] pats [7];
    pats = '{32'h0, 32'hffffffff, 32'h0000ffff, 32'hffff0000,
             32'haaaaaaaa, 32'h00ffff00, 32'hf0f0f0f0};
    for (int i = 0; i < 120; i++) begin
      logic [31:0] w;
      int sel = $urandom_range(0, 9);
      w = (sel < 7) ? pats[sel] : $urandom;
      if (model_word(w)) exp_q.push_back(w);
      send_word(w);
      wait_edges($urandom_range(0, 3));
    end
    prod_done = 1;
  endtask

  task automatic monitor();
    logic [31:0] st, d;
    int cyc = 0, quiet = 0;
    while (cyc < 40000) begin
      cs = 1; we = 0; address = A_STATUS;
      #1 st = read_data;
      if (st[2:1] != 2'b00) begin
        we = 1; address = A_CTRL; write_data = 32'h1; quiet = 0;
      end else if (st[0]) begin
        address = A_DATA;
        #1 d = read_data;
        quiet = 0;
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sb_unexpected_word: got %h, none expected", d);
        end else begin
          chk("sb_word", d, exp_q.pop_front());
        end
      end else begin
        cs = 0; quiet++;
      end
      @(posedge clk); #1;
      cs = 0; we = 0; cyc++;
      if (prod_done && quiet > 50) break;
    end
    chk("sb_no_timeout", {31'd0, cyc >= 40000}, 32'd0);
    chk("sb_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    reset_n = 0; raw_valid = 0; raw_data = 0;
    cs = 0; we = 0; address = 0; write_data = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;

    // Reset state
    chk("rst_raw_ack", {31'd0, raw_ack}, 32'd0);
    peek(A_STATUS, d); chk("rst_status", d, 32'd0);
    peek(A_WORDS, d);  chk("rst_words", d, 32'd0);
    peek(A_DATA, d);   chk("rst_data", d, 32'd0);

    // Alternating word: handshake, latency, readout
    raw_data = 32'haaaaaaaa; raw_valid = 1;
    #1 chk("alt_ack", {31'd0, raw_ack}, 32'd1);
    @(posedge clk); #1 raw_valid = 0;
    chk("alt_ack_drop", {31'd0, raw_ack}, 32'd0);
    wait_edges(32);
    peek(A_STATUS, d); chk("alt_not_yet_e32", d, 32'd0);
    wait_edges(1);
    peek(A_STATUS, d); chk("alt_status_e33", d, 32'd1);
    peek(A_DATA, d);   chk("alt_data", d, 32'haaaaaaaa);
    peek(A_WORDS, d);  chk("alt_words", d, 32'd1);
    rd_data_edge();
    peek(A_STATUS, d); chk("alt_status_after_rd", d, 32'd0);
    words_exp = 1;

    // RCT failure on an all-zero word, blocking, then clear
    wr(A_CTRL, 32'h1);
    run_word(32'h0, 32'h2, "rct_status");
    raw_data = 32'h0000ffff; raw_valid = 1;
    #1 chk("rct_no_ack", {31'd0, raw_ack}, 32'd0);
    wait_edges(2);
    chk("rct_no_ack2", {31'd0, raw_ack}, 32'd0);
    cs = 1; we = 1; address = A_CTRL; write_data = 32'h1;
    #1 chk("clr_cycle_no_ack", {31'd0, raw_ack}, 32'd0);
    @(posedge clk); #1 cs = 0; we = 0;
    peek(A_STATUS, d); chk("rct_cleared", d, 32'd0);
    raw_valid = 0;
    run_word(32'h0000ffff, 32'h1, "rct_next_word");
    peek(A_WORDS, d); chk("rct_words", d, words_exp);

    // APT: balanced window passes, skewed window fails at its end
    wr(A_CTRL, 32'h1);
    for (int i = 0; i < 32; i++) run_word(32'h0f0f0f0f, 32'h1, "apt_balanced");
    for (int i = 0; i < 31; i++) run_word(32'hfffeffff, 32'h1, "apt_skew_pass");
    run_word(32'hfffeffff, 32'h4, "apt_fail_status");
    wr(A_CTRL, 32'h1);
    peek(A_WORDS, d); chk("apt_words", d, words_exp);

    // Backpressure: second word held in COMMIT until DATA read
    send_word(32'h12345678);
    wait_edges(33);
    send_word(32'h9abcdef0);
    wait_edges(33);
    raw_data = 32'h55555555; raw_valid = 1;
    #1 chk("bp_no_ack", {31'd0, raw_ack}, 32'd0);
    wait_edges(3);
    chk("bp_no_ack2", {31'd0, raw_ack}, 32'd0);
    raw_valid = 0;
    peek(A_DATA, d); chk("bp_first", d, 32'h12345678);
    rd_data_edge();
    peek(A_STATUS, d); chk("bp_gap", d, 32'd0);
    wait_edges(1);
    peek(A_STATUS, d); chk("bp_commit", d, 32'd1);
    peek(A_DATA, d);   chk("bp_second", d, 32'h9abcdef0);
    words_exp += 2;
    peek(A_WORDS, d);  chk("bp_words", d, words_exp);
    rd_data_edge();

    // Clear at E10, then reset at E5 of the next word
    send_word(32'hc3c3c3c3);
    wait_edges(9);
    wr(A_CTRL, 32'h1);
    wait_edges(30);
    peek(A_STATUS, d); chk("clr_drop_status", d, 32'd0);
    peek(A_WORDS, d);  chk("clr_drop_words", d, words_exp);
    raw_data = 32'h3c3c3c3c; raw_valid = 1;
    cs = 1; we = 1; address = A_CTRL; write_data = 32'h1;
    #1 chk("idle_clr_no_ack", {31'd0, raw_ack}, 32'd0);
    @(posedge clk); #1 cs = 0; we = 0;
    #1 chk("post_clr_ack", {31'd0, raw_ack}, 32'd1);
    @(posedge clk); #1 raw_valid = 0;
    wait_edges(4);
    reset_n = 0;
    wait_edges(1);
    reset_n = 1;
    wait_edges(40);
    peek(A_STATUS, d); chk("rstmid_status", d, 32'd0);
    peek(A_WORDS, d);  chk("rstmid_words", d, 32'd0);

    // Register API corners
    peek(8'h33, d); chk("undef_read", d, 32'd0);
    wr(A_DATA, 32'h12345678);
    peek(A_DATA, d); chk("data_write_ignored", d, 32'd0);
    chk("ready_idle", {31'd0, ready}, 32'd0);

    // Randomized scoreboard phase from fresh state
    words_exp = 0;
    fork
      producer();
      monitor();
    join

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
